window_serializer: RTL



---
 rtl/window_pkg.sv | 18 +
 rtl/window_bank.sv | 30 +++
 rtl/window_serializer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/window_pkg.sv
// Shared types for the window pipeline: FSM states, sample type, index-width helper.
// Ping-pong buffering in window_serializer is enabled by defining WINDOW_SER_PINGPONG_EN.
package window_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   localparam int unsigned SAMPLE_W = 16;
   typedef logic [SAMPLE_W-1:0] sample_t;

   // Keeps index ports at least one bit wide even for tiny windows.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/window_bank.sv
// One WINDOW_SIZE-deep sample register bank with parallel load and indexed read.
// Instantiated twice by window_serializer when WINDOW_SER_PINGPONG_EN is defined.
module window_bank
   import window_pkg::*;
#(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned WINDOW_SIZE = 32,
   localparam int unsigned IDX_W      = idx_width(WINDOW_SIZE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i [0:WINDOW_SIZE-1],
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [0:WINDOW_SIZE-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < WINDOW_SIZE; i++) mem_q[i] <= '0;
      end else if (load_i) begin
         for (int unsigned i = 0; i < WINDOW_SIZE; i++) mem_q[i] <= data_i[i];
      end
   end

   assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/window_serializer.sv
// Parallel window in, one sample per accepted beat out, oldest sample first.
// Define WINDOW_SER_PINGPONG_EN for two banks and zero-bubble window switching.
module window_serializer
   import window_pkg::*;
#(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned WINDOW_SIZE = 32,
   localparam int unsigned IDX_W      = idx_width(WINDOW_SIZE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              win_valid,
   output logic              win_ready,
   input  logic [DATA_W-1:0] win_data [0:WINDOW_SIZE-1],
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_index,
   output logic              out_last,
   output logic              busy
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW_SIZE - 1);

   state_t             state_q;
   logic [IDX_W-1:0]   rd_ptr_q;
   logic               out_last_q;
   logic               busy_q;

`ifdef WINDOW_SER_PINGPONG_EN
   logic               act_q, act_d;
   logic [1:0]         full_q, full_d;
   logic [IDX_W-1:0]   rd_ptr_d;
   logic               fire, last_fire, load, tgt, swap, valid_d;
   logic [DATA_W-1:0]  rd_data0, rd_data1;

   assign fire      = (state_q == STREAM) && out_ready;
   assign last_fire = fire && out_last_q;
   assign win_ready = !full_q[~act_q] || last_fire;
   assign load      = win_valid && win_ready;
   // Spare bank takes the load only while the active one is still streaming;
   // otherwise the active slot is free (idle, or draining its last beat now).
   assign tgt       = (full_q[act_q] && !full_q[~act_q]) ? ~act_q : act_q;
   assign swap      = full_q[~act_q] || (load && (tgt != act_q));

   always_comb begin
      full_d   = full_q;
      act_d    = act_q;
      rd_ptr_d = rd_ptr_q;
      if (last_fire) begin
         full_d[act_q] = 1'b0;
         rd_ptr_d      = '0;
         if (swap) act_d = ~act_q;
      end else if (fire) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (load) full_d[tgt] = 1'b1;
      valid_d = full_d[act_d];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rd_ptr_q   <= '0;
         act_q      <= 1'b0;
         full_q     <= '0;
         out_last_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= valid_d ? STREAM : IDLE;
         rd_ptr_q   <= rd_ptr_d;
         act_q      <= act_d;
         full_q     <= full_d;
         out_last_q <= valid_d && (rd_ptr_d == LAST_IDX);
         busy_q     <= |full_d;
      end
   end

   window_bank #(.DATA_W(DATA_W), .WINDOW_SIZE(WINDOW_SIZE)) u_bank0 (
      .clk       (clk),
      .rst       (rst),
      .load_i    (load && (tgt == 1'b0)),
      .data_i    (win_data),
      .rd_idx_i  (rd_ptr_q),
      .rd_data_o (rd_data0)
   );

   window_bank #(.DATA_W(DATA_W), .WINDOW_SIZE(WINDOW_SIZE)) u_bank1 (
      .clk       (clk),
      .rst       (rst),
      .load_i    (load && (tgt == 1'b1)),
      .data_i    (win_data),
      .rd_idx_i  (rd_ptr_q),
      .rd_data_o (rd_data1)
   );

   assign out_data = act_q ? rd_data1 : rd_data0;
`else
   localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(WINDOW_SIZE - 2);

   logic load;

   assign win_ready = (state_q == IDLE);
   assign load      = win_ready && win_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rd_ptr_q   <= '0;
         out_last_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (win_valid) begin
                  state_q    <= STREAM;
                  rd_ptr_q   <= '0;
                  out_last_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            STREAM: begin
               if (out_ready) begin
                  if (rd_ptr_q == LAST_IDX) begin
                     state_q    <= IDLE;
                     rd_ptr_q   <= '0;
                     out_last_q <= 1'b0;
                     busy_q     <= 1'b0;
                  end else begin
                     rd_ptr_q   <= rd_ptr_q + 1'b1;
                     out_last_q <= (rd_ptr_q == PENULT_IDX);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   window_bank #(.DATA_W(DATA_W), .WINDOW_SIZE(WINDOW_SIZE)) u_bank0 (
      .clk       (clk),
      .rst       (rst),
      .load_i    (load),
      .data_i    (win_data),
      .rd_idx_i  (rd_ptr_q),
      .rd_data_o (out_data)
   );
`endif

   assign out_valid = (state_q == STREAM);
   assign out_index = rd_ptr_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;

endmodule
